// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream packet source with framed, incrementing-counter payloads.
// Latency: a start pulse in cycle N gives the first tvalid in cycle N+1. Beats go back-to-back when tready=1 and gap=0.
// Backpressure: tvalid/tdata/tlast stay put until the handshake, and packets are never truncated.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, stop              run launch pulse (sampled in IDLE); run stop (sticky while busy)
//   cfg_len/num_pkts/gap/seed  run configuration, latched on start
//   m_axis_tvalid/tready/tdata/tlast  AXI-Stream master port
//   busy, done, pkt_count    run status
module axis_pkt_gen #(
   parameter int P_DATA_WIDTH = 16,
   parameter int P_LEN_WIDTH  = 16,
   parameter int P_GAP_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic [P_LEN_WIDTH-1:0]  cfg_len,
   input  logic [15:0]             cfg_num_pkts,
   input  logic [P_GAP_WIDTH-1:0]  cfg_gap,
   input  logic [P_DATA_WIDTH-1:0] cfg_seed,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [P_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tlast,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             pkt_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

   state_t                 state;
   state_t                 state_nxt;

   logic [P_LEN_WIDTH-1:0] len_m1;
   logic [P_LEN_WIDTH-1:0] len_m1_nxt;
   logic [P_LEN_WIDTH-1:0] cfg_len_m1;
   logic [P_LEN_WIDTH-1:0] beat;
   logic [P_LEN_WIDTH-1:0] beat_nxt;
   logic [15:0]            num_pkts;
   logic [P_GAP_WIDTH-1:0] gap_len;
   logic [P_GAP_WIDTH-1:0] gap_cnt;
   logic                   stop_flag;

   logic                   hs;
   logic                   last_hs;
   logic                   stop_seen;
   logic                   pkts_reached;
   logic                   end_run;
   logic                   launch;

   logic                   tvalid_nxt;
   logic                   tlast_nxt;
   logic                   busy_nxt;
   logic                   done_nxt;

   // A zero length is treated as a single-beat packet.
   assign cfg_len_m1   = (cfg_len == '0) ? '0 : cfg_len - P_LEN_WIDTH'(1);

   assign launch       = (state == IDLE) && start;
   assign hs           = m_axis_tvalid && m_axis_tready;
   assign last_hs      = hs && m_axis_tlast;
   // A stop arriving in the same cycle as the deciding event counts as seen.
   assign stop_seen    = stop_flag || stop;
   assign pkts_reached = (num_pkts != 16'd0) && ((pkt_count + 16'd1) == num_pkts);
   assign end_run      = last_hs && (stop_seen || pkts_reached);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = SEND;
         end
         SEND: begin
            if (last_hs) begin
               if (end_run)              state_nxt = IDLE;
               else if (gap_len != '0)   state_nxt = GAP;
               else                      state_nxt = SEND;
            end
         end
         GAP: begin
            if (stop_seen)                        state_nxt = IDLE;
            else if (gap_cnt == P_GAP_WIDTH'(1))  state_nxt = SEND;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs. tlast is derived
   // from the next beat index so it is already valid with the beat it marks.
   always_comb begin
      len_m1_nxt = launch ? cfg_len_m1 : len_m1;
      beat_nxt   = beat;
      if (launch) begin
         beat_nxt = '0;
      end else if (hs) begin
         beat_nxt = m_axis_tlast ? '0 : beat + P_LEN_WIDTH'(1);
      end
      tvalid_nxt = (state_nxt == SEND);
      tlast_nxt  = (state_nxt == SEND) && (beat_nxt == len_m1_nxt);
      busy_nxt   = (state_nxt != IDLE);
      done_nxt   = (state != IDLE) && (state_nxt == IDLE);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pkt_count     <= 16'd0;
         len_m1        <= '0;
         beat          <= '0;
         num_pkts      <= 16'd0;
         gap_len       <= '0;
         gap_cnt       <= '0;
         stop_flag     <= 1'b0;
      end else begin
         m_axis_tvalid <= tvalid_nxt;
         m_axis_tlast  <= tlast_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         len_m1        <= len_m1_nxt;
         beat          <= beat_nxt;

         // tdata doubles as the payload counter; it runs on across packets.
         if (launch) begin
            num_pkts     <= cfg_num_pkts;
            gap_len      <= cfg_gap;
            m_axis_tdata <= cfg_seed;
            pkt_count    <= 16'd0;
         end else begin
            if (hs)      m_axis_tdata <= m_axis_tdata + P_DATA_WIDTH'(1);
            if (last_hs) pkt_count    <= pkt_count + 16'd1;
         end

         if (last_hs)           gap_cnt <= gap_len;
         else if (state == GAP) gap_cnt <= gap_cnt - P_GAP_WIDTH'(1);

         if (done_nxt)                    stop_flag <= 1'b0;
         else if (state != IDLE && stop)  stop_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: scoreboard of expected beats checked by a monitor.
// Stimulus drives inputs 1 time unit after the rising edge; the monitor samples on the falling edge.
// Each beat records how many tvalid-low cycles preceded it, so gaps and back-to-back spacing are checked.
module tb_axis_pkt_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic [15:0] cfg_len;
   logic [15:0] cfg_num_pkts;
   logic [7:0]  cfg_gap;
   logic [15:0] cfg_seed;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tlast;
   logic        busy;
   logic        done;
   logic [15:0] pkt_count;

   axis_pkt_gen dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stop          (stop),
      .cfg_len       (cfg_len),
      .cfg_num_pkts  (cfg_num_pkts),
      .cfg_gap       (cfg_gap),
      .cfg_seed      (cfg_seed),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy),
      .done          (done),
      .pkt_count     (pkt_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic        l;
      int          gap;   // expected tvalid-low cycles before this beat, -1 = unchecked
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_hs_cyc = -100;
   logic rand_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_beat(input logic [15:0] d, input logic l, input int g);
      exp_t e;
      e.d = d; e.l = l; e.gap = g;
      q.push_back(e);
   endtask

   // Expected beats for a run of npk packets of len beats starting from seed.
   task automatic push_run(input logic [15:0] seed, input int len, input int npk, input int gap_exp);
      logic [15:0] d;
      d = seed;
      for (int p = 0; p < npk; p++) begin
         for (int b = 0; b < len; b++) begin
            push_beat(d, (b == len - 1), (p == 0 && b == 0) ? -1 : ((b == 0) ? gap_exp : 0));
            d = d + 16'd1;
         end
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
   endtask

   // Monitor: pops the scoreboard on every handshake and checks AXI hold rules.
   logic        stall = 1'b0;
   logic [15:0] hold_d;
   logic        hold_l;
   int          lowcnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         stall  = 1'b0;
         lowcnt = 0;
      end else begin
         if (stall) begin
            chk("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
            chk("hold_tdata",  32'(m_axis_tdata),  32'(hold_d));
            chk("hold_tlast",  32'(m_axis_tlast),  32'(hold_l));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got tdata 0x%0h with no beat expected (cycle %0d)", m_axis_tdata, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("beat_tdata", 32'(m_axis_tdata), 32'(e.d));
               chk("beat_tlast", 32'(m_axis_tlast), 32'(e.l));
               if (e.gap >= 0) chk("beat_gap", 32'(lowcnt), 32'(e.gap));
            end
            if (m_axis_tlast) last_hs_cyc = cyc;
            lowcnt = 0;
         end else if (!m_axis_tvalid) begin
            lowcnt++;
         end
         stall  = m_axis_tvalid && !m_axis_tready;
         hold_d = m_axis_tdata;
         hold_l = m_axis_tlast;
      end
   end

   task automatic pulse_start;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   // Wait for done, then check its timing, busy, pkt_count and the drained scoreboard.
   task automatic wait_done(input string name, input int bound, input logic [15:0] exp_cnt);
      int n;
      n = 0;
      while (done !== 1'b1 && n < bound) begin
         tick;
         n++;
      end
      if (done !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: done not seen within %0d cycles", name, bound);
      end else begin
         chk({name, "_done_lat"}, 32'(cyc - last_hs_cyc), 32'd1);
         chk({name, "_busy"},     32'(busy),       32'd0);
         chk({name, "_pkts"},     32'(pkt_count),  32'(exp_cnt));
         tick;
         chk({name, "_done_1cyc"}, 32'(done), 32'd0);
      end
      rand_rdy      = 1'b0;
      m_axis_tready = 1'b1;
      repeat (4) tick;
      chk({name, "_drained"}, 32'(q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
      cfg_len = 16'd4; cfg_num_pkts = 16'd1; cfg_gap = 8'd0; cfg_seed = 16'h0010;
      repeat (3) tick;
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
      chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
      chk("rst_busy",   32'(busy),          32'd0);
      chk("rst_done",   32'(done),          32'd0);
      chk("rst_pkts",   32'(pkt_count),     32'd0);
      rst = 1'b0;
      tick;

      // Single packet, hand-computed beats
      push_beat(16'h0010, 1'b0, -1);
      push_beat(16'h0011, 1'b0, 0);
      push_beat(16'h0012, 1'b0, 0);
      push_beat(16'h0013, 1'b1, 0);
      pulse_start;
      chk("single_first_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("single_busy", 32'(busy), 32'd1);
      wait_done("single", 50, 16'd1);

      // Backpressure: random tready, hold rules checked by the monitor
      cfg_len = 16'd8; cfg_num_pkts = 16'd1; cfg_gap = 8'd0; cfg_seed = 16'h1234;
      push_run(16'h1234, 8, 1, 0);
      rand_rdy = 1'b1;
      pulse_start;
      wait_done("backpressure", 200, 16'd1);

      // Gap + multi-packet with payload wrap, hand-computed beats
      cfg_len = 16'd2; cfg_num_pkts = 16'd3; cfg_gap = 8'd3; cfg_seed = 16'hFFFE;
      push_beat(16'hFFFE, 1'b0, -1);
      push_beat(16'hFFFF, 1'b1, 0);
      push_beat(16'h0000, 1'b0, 3);
      push_beat(16'h0001, 1'b1, 0);
      push_beat(16'h0002, 1'b0, 3);
      push_beat(16'h0003, 1'b1, 0);
      pulse_start;
      wait_done("gap", 100, 16'd3);

      // Continuous run, stop on the 2nd beat of packet 3
      cfg_len = 16'd5; cfg_num_pkts = 16'd0; cfg_gap = 8'd0; cfg_seed = 16'h0200;
      push_run(16'h0200, 5, 3, 0);
      pulse_start;
      repeat (11) tick;
      chk("stop_beat_pos", 32'(m_axis_tdata), 32'h020B);
      stop = 1'b1;
      tick;
      stop = 1'b0;
      wait_done("stop", 50, 16'd3);

      // Zero length plus a start (with new config) while busy
      cfg_len = 16'd0; cfg_num_pkts = 16'd3; cfg_gap = 8'd1; cfg_seed = 16'h0050;
      push_beat(16'h0050, 1'b1, -1);
      push_beat(16'h0051, 1'b1, 1);
      push_beat(16'h0052, 1'b1, 1);
      pulse_start;
      tick;
      cfg_seed = 16'h9999; cfg_len = 16'd7; cfg_num_pkts = 16'd9; cfg_gap = 8'd0;
      pulse_start;
      wait_done("edge", 50, 16'd3);

      // Reset in the middle of a packet, then a clean restart
      cfg_len = 16'd6; cfg_num_pkts = 16'd1; cfg_gap = 8'd0; cfg_seed = 16'h0100;
      push_beat(16'h0100, 1'b0, -1);
      push_beat(16'h0101, 1'b0, 0);
      pulse_start;
      tick;
      tick;
      chk("rstmid_beat3", 32'(m_axis_tdata), 32'h0102);
      m_axis_tready = 1'b0;
      rst = 1'b1;
      tick;
      chk("rstmid_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rstmid_tlast",  32'(m_axis_tlast),  32'd0);
      chk("rstmid_busy",   32'(busy),          32'd0);
      chk("rstmid_done",   32'(done),          32'd0);
      chk("rstmid_tdata",  32'(m_axis_tdata),  32'd0);
      chk("rstmid_pkts",   32'(pkt_count),     32'd0);
      rst = 1'b0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("rstmid_no_done", 32'({done, m_axis_tvalid}), 32'd0);
      end
      chk("rstmid_drained", 32'(q.size()), 32'd0);
      push_run(16'h0100, 6, 1, 0);
      pulse_start;
      chk("restart_pkts", 32'(pkt_count), 32'd0);
      wait_done("restart", 50, 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
